decode_issue_scoreboard: RTL and testbench

- Parametrised decode-to-execute issue stage for the CPU pipeline.
- Accepts decoded instructions over a valid/ready handshake and holds one instruction in an output register.
- Tracks in-flight register writes with per-register countdown counters, and stalls issue on RAW and WAW hazards.
- Provides flush, a busy-register mask and a hazard-stall counter for debug.

---
 rtl/decode_issue_scoreboard.sv | 141 ++++++++++++++
 tb/tb_decode_issue_scoreboard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_scoreboard.sv
// rtl/decode_issue_scoreboard.sv - decode-to-execute issue stage with RAW/WAW scoreboard
module decode_issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int INSTR_W  = 32,
  parameter int LAT_W    = 3,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [REG_AW-1:0]  in_rs1,
  input  logic               in_rs1_used,
  input  logic [REG_AW-1:0]  in_rs2,
  input  logic               in_rs2_used,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic               in_rd_we,
  input  logic [LAT_W-1:0]   in_lat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [REG_AW-1:0]  out_rd,
  output logic               out_rd_we,
  output logic [LAT_W-1:0]   out_lat,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]        hazard_stalls
);

  // Output register holding the instruction offered to execute.
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [REG_AW-1:0]  out_rd_q;
  logic               out_rd_we_q;
  logic [LAT_W-1:0]   out_lat_q;

  // Per-register remaining-latency counters for instructions already in execute.
  logic [LAT_W-1:0]   cnt_q [NUM_REGS];
  logic [LAT_W-1:0]   cnt_d [NUM_REGS];

  logic [15:0]        stalls_q;
  logic [15:0]        stalls_d;

  logic [NUM_REGS-1:0] pending;
  logic               hazard;
  logic               space;
  logic               issue;
  logic               out_hs;
  logic               load_en;

  // A register is pending while its counter runs or while its writer sits in the output register.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = (cnt_q[r] != '0) ||
                   (out_valid_q && out_rd_we_q && (out_rd_q == REG_AW'(r)));
      if ((ZERO_REG != 0) && (r == 0)) begin
        pending[r] = 1'b0;
      end
    end
  end

  assign hazard   = (in_rs1_used && pending[in_rs1]) ||
                    (in_rs2_used && pending[in_rs2]) ||
                    (in_rd_we    && pending[in_rd]);
  assign space    = !out_valid_q || out_ready;
  assign in_ready = !flush && !hazard && space;
  assign issue    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready && !flush;
  // Writes to a hardwired zero register never enter the scoreboard.
  assign load_en  = out_rd_we_q && !((ZERO_REG != 0) && (out_rd_q == '0));

  // Counters count down every cycle; a handshake reload wins over the decrement.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if (out_hs && load_en && (out_rd_q == REG_AW'(r))) begin
        cnt_d[r] = out_lat_q;
      end
    end
  end

  // Only genuine scoreboard stalls are counted, never backpressure or flush cycles.
  always_comb begin
    stalls_d = stalls_q;
    if (in_valid && hazard && !flush && (stalls_q != 16'hFFFF)) begin
      stalls_d = stalls_q + 16'd1;
    end
  end

  // Output register: load on issue, otherwise drop on handshake or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      out_lat_q   <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_instr_q <= in_instr;
      out_rd_q    <= in_rd;
      out_rd_we_q <= in_rd_we;
      out_lat_q   <= in_lat;
    end else if (out_hs || flush) begin
      out_valid_q <= 1'b0;
    end
  end

  // Scoreboard counters and the debug stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      stalls_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stalls_q <= stalls_d;
    end
  end

  // A zero latency would make the producer invisible to its consumers.
  assert property (@(posedge clk) disable iff (!rst_n) issue |-> (in_lat != '0));

  assign out_valid     = out_valid_q;
  assign out_instr     = out_instr_q;
  assign out_rd        = out_rd_q;
  assign out_rd_we     = out_rd_we_q;
  assign out_lat       = out_lat_q;
  assign busy_mask     = pending;
  assign hazard_stalls = stalls_q;

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// tb/tb_decode_issue_scoreboard.sv - scoreboard bench for decode_issue_scoreboard
module tb_decode_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  in_rs1;
  logic        in_rs1_used;
  logic [3:0]  in_rs2;
  logic        in_rs2_used;
  logic [3:0]  in_rd;
  logic        in_rd_we;
  logic [2:0]  in_lat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [3:0]  out_rd;
  logic        out_rd_we;
  logic [2:0]  out_lat;
  logic [15:0] busy_mask;
  logic [15:0] hazard_stalls;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];
  logic [15:0] s0;

  decode_issue_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs1_used(in_rs1_used),
    .in_rs2(in_rs2), .in_rs2_used(in_rs2_used),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_lat(in_lat),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_lat(out_lat),
    .busy_mask(busy_mask), .hazard_stalls(hazard_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, count cycles until accepted, log expected output.
  task automatic send(input logic [31:0] instr,
                      input logic [3:0] rs1, input logic u1,
                      input logic [3:0] rs2, input logic u2,
                      input logic [3:0] rd, input logic we,
                      input logic [2:0] lat, input int exp_stall, input string nm);
    int st;
    st = 0;
    in_valid = 1'b1; in_instr = instr;
    in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
    in_rd = rd; in_rd_we = we; in_lat = lat;
    @(negedge clk);
    while (!in_ready && st < 60) begin
      st++;
      @(negedge clk);
    end
    if (in_ready) exp_q.push_back({instr, rd, we, lat});
    chk({nm, " stalls"}, 64'(st), 64'(exp_stall));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((out_valid || busy_mask != '0) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " idle"}, 64'(out_valid || busy_mask != '0), 64'(0));
    sync();
  endtask

  // Monitor: every accepted or flushed output pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && (flush || out_ready)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out pkt: got %0h expected none", out_instr);
      end else if (flush) begin
        chk("flushed instr", 64'(out_instr), 64'(exp_q[0][39:8]));
        void'(exp_q.pop_front());
      end else begin
        chk("out pkt", 64'({out_instr, out_rd, out_rd_we, out_lat}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_rs1 = '0; in_rs1_used = 1'b0; in_rs2 = '0; in_rs2_used = 1'b0;
    in_rd = '0; in_rd_we = 1'b0; in_lat = 3'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_instr", 64'(out_instr), 64'(0));
    chk("rst out_rd", 64'({out_rd, out_rd_we, out_lat}), 64'(0));
    chk("rst busy", 64'(busy_mask), 64'(0));
    chk("rst stalls", 64'(hazard_stalls), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));
    sync();
    rst_n = 1'b1;

    // Producer r3 lat 2: busy for exactly 3 cycles.
    send(32'h1000_0003, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 3'd2, 0, "t1 add");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) chk("t1 out_valid", 64'(out_valid), 64'(1));
      if (!busy_mask[3]) break;
      n++;
    end
    chk("t1 busy cycles", 64'(n), 64'(3));
    chk("t1 stalls", 64'(hazard_stalls), 64'(0));
    wait_idle("t1");

    // RAW consumer presented right after the producer.
    s0 = hazard_stalls;
    send(32'h2000_0003, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 3'd2, 0, "t2 prod");
    send(32'h2000_0004, 4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 3'd1, 3, "t2 cons");
    chk("t2 hazard_stalls", 64'(hazard_stalls - s0), 64'(3));
    wait_idle("t2");

    // WAW on r4, RAW through rs2, unused source ignored.
    send(32'h2100_0004, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 3'd1, 0, "waw prod");
    send(32'h2100_0005, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 3'd1, 2, "waw cons");
    wait_idle("waw");
    send(32'h2200_0006, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 3'd1, 0, "rs2 prod");
    send(32'h2200_0007, 4'd1, 1'b1, 4'd6, 1'b1, 4'd11, 1'b1, 3'd1, 2, "rs2 cons");
    wait_idle("rs2");
    send(32'h2300_0008, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 3'd5, 0, "unused prod");
    send(32'h2300_0009, 4'd8, 1'b0, 4'd8, 1'b0, 4'd10, 1'b1, 3'd1, 0, "unused cons");
    wait_idle("unused");

    // Backpressure: out_ready low 5 cycles, consumer of r5 waits through lat 3.
    out_ready = 1'b0;
    s0 = hazard_stalls;
    send(32'h3000_0005, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 3'd3, 0, "t3 prod");
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    send(32'h3000_0006, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 3'd1, 9, "t3 cons");
    chk("t3 hazard_stalls", 64'(hazard_stalls - s0), 64'(9));
    wait_idle("t3");

    // Flush the r7 writer while its consumer waits.
    out_ready = 1'b0;
    s0 = hazard_stalls;
    send(32'h4000_0007, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 3'd2, 0, "t4 prod");
    fork
      begin
        sync();
        flush = 1'b1;
        sync();
        flush = 1'b0;
        @(negedge clk);
        chk("t4 out_valid", 64'(out_valid), 64'(0));
        chk("t4 busy7", 64'(busy_mask[7]), 64'(0));
      end
    join_none
    send(32'h4000_0008, 4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 3'd1, 2, "t4 cons");
    chk("t4 hazard_stalls", 64'(hazard_stalls - s0), 64'(1));
    out_ready = 1'b1;
    wait_idle("t4");

    // Writes to and reads of r0 never stall.
    s0 = hazard_stalls;
    for (int i = 0; i < 6; i++) begin
      send(32'h5000_0000 + 32'(i), 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 3'd3, 0, "t5 r0");
      chk("t5 busy0", 64'(busy_mask[0]), 64'(0));
    end
    chk("t5 hazard_stalls", 64'(hazard_stalls - s0), 64'(0));
    wait_idle("t5");

    // Asynchronous reset mid-stream.
    send(32'h6000_0002, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 3'd4, 0, "t6 prod");
    send(32'h6000_0009, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 3'd1, 0, "t6 second");
    chk("t6 pre busy2", 64'(busy_mask[2]), 64'(1));
    chk("t6 pre out_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 out_valid", 64'(out_valid), 64'(0));
    chk("t6 busy", 64'(busy_mask), 64'(0));
    chk("t6 stalls", 64'(hazard_stalls), 64'(0));
    chk("t6 out_instr", 64'(out_instr), 64'(0));
    chk("t6 in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    sync();
    rst_n = 1'b1;
    send(32'h6100_0001, 4'd2, 1'b1, 4'd9, 1'b1, 4'd2, 1'b1, 3'd1, 0, "t6 post");
    wait_idle("t6");
    chk("queue empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
